// File: rtl/fancy_counter.sv
// 16-bit free-running counter with a "fancy" derived output built from the
// current count and the count it held before the last increment.
module fancy_counter (
  input  logic        clk,
  input  logic        nreset,
  input  logic        enable,
  output logic [15:0] data,
  output logic [15:0] fancy_data
);

  localparam logic [15:0] FANCY_AT_0  = 16'd17;
  localparam logic [15:0] FANCY_AT_1  = 16'd1287;
  localparam logic [15:0] FANCY_AT_17 = 16'd2137;

  // Declaration initialisers give defined outputs before the first reset edge.
  logic [15:0] cnt  = 16'h0000;
  logic [15:0] prev = 16'h0000;

  // Synchronous reset wins over enable; prev and cnt always move together.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      cnt  <= 16'h0000;
      prev <= 16'h0000;
    end else if (enable) begin
      prev <= cnt;
      cnt  <= cnt + 16'd1;
    end
  end

  assign data = cnt;

  // Carry out of the 16-bit sum is intentionally dropped.
  always_comb begin
    fancy_data = (prev ^ cnt) + cnt;
    if (cnt == 16'd0) begin
      fancy_data = FANCY_AT_0;
    end else if (cnt == 16'd1) begin
      fancy_data = FANCY_AT_1;
    end else if (cnt == 16'd17) begin
      fancy_data = FANCY_AT_17;
    end
  end

endmodule

// File: tb/tb_fancy_counter.sv
// Self-checking bench for fancy_counter: directed scenarios plus a long
// randomized run (including a full wrap) against an arithmetic reference model.
module tb_fancy_counter;

  logic        clk = 1'b0;
  logic        nreset;
  logic        enable;
  logic [15:0] data;
  logic [15:0] fancy_data;

  int errors = 0;
  int checks = 0;

  // Reference model: plain integers, wrapped with modulo arithmetic.
  int m_cnt  = 0;
  int m_prev = 0;

  logic [15:0] exp_d;
  logic [15:0] exp_f;

  fancy_counter dut (
    .clk        (clk),
    .nreset     (nreset),
    .enable     (enable),
    .data       (data),
    .fancy_data (fancy_data)
  );

  always #5 clk = ~clk;

  function automatic int ref_fancy(input int c, input int p);
    if (c == 0)  return 17;
    if (c == 1)  return 1287;
    if (c == 17) return 2137;
    return ((p ^ c) + c) % 65536;
  endfunction

  // Drive one edge and advance the model; outputs are sampled 1ns after the edge.
  task automatic step(input logic en, input logic nr);
    enable = en;
    nreset = nr;
    @(posedge clk);
    if (!nr) begin
      m_cnt  = 0;
      m_prev = 0;
    end else if (en) begin
      m_prev = m_cnt;
      m_cnt  = (m_cnt + 1) % 65536;
    end
    exp_d = 16'(m_cnt);
    exp_f = 16'(ref_fancy(m_cnt, m_prev));
    #1;
  endtask

  task automatic test_power_up;
    #1;
    checks++;
    if (data !== 16'h0000 || fancy_data !== 16'd17) begin
      errors++;
      $display("FAIL power_up: data=%0d fancy=%0d expected data=0 fancy=17", data, fancy_data);
    end
  endtask

  task automatic test_reset;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0);
      checks++;
      if (data !== 16'h0000 || fancy_data !== 16'd17) begin
        errors++;
        $display("FAIL reset_hold[%0d]: data=%0d fancy=%0d expected data=0 fancy=17", i, data, fancy_data);
      end
    end
  endtask

  task automatic test_count_from_reset;
    logic [15:0] td [3];
    logic [15:0] tf [3];
    td = '{16'd1, 16'd2, 16'd3};
    tf = '{16'd1287, 16'd5, 16'd4};
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1);
      checks++;
      if (data !== td[i] || fancy_data !== tf[i]) begin
        errors++;
        $display("FAIL count_from_reset[%0d]: data=%0d fancy=%0d expected data=%0d fancy=%0d",
                 i, data, fancy_data, td[i], tf[i]);
      end
    end
  endtask

  task automatic test_enable_low;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1);
      checks++;
      if (data !== 16'd3 || fancy_data !== 16'd4) begin
        errors++;
        $display("FAIL enable_low[%0d]: data=%0d fancy=%0d expected data=3 fancy=4", i, data, fancy_data);
      end
    end
    step(1'b1, 1'b1);
    checks++;
    if (data !== 16'd4 || fancy_data !== 16'd11) begin
      errors++;
      $display("FAIL re_enable: data=%0d fancy=%0d expected data=4 fancy=11", data, fancy_data);
    end
  endtask

  task automatic test_special_17;
    int budget = 100;
    while (m_cnt != 17 && budget > 0) begin
      step(1'($urandom_range(0, 3) != 0), 1'b1);
      budget--;
      checks++;
      if (data !== exp_d || fancy_data !== exp_f) begin
        errors++;
        $display("FAIL to_17: data=%0d fancy=%0d expected data=%0d fancy=%0d", data, fancy_data, exp_d, exp_f);
      end
    end
    checks++;
    if (data !== 16'd17 || fancy_data !== 16'd2137) begin
      errors++;
      $display("FAIL special_17: data=%0d fancy=%0d expected data=17 fancy=2137", data, fancy_data);
    end
    step(1'b1, 1'b1);
    checks++;
    if (data !== 16'd18 || fancy_data !== 16'd21) begin
      errors++;
      $display("FAIL after_17: data=%0d fancy=%0d expected data=18 fancy=21", data, fancy_data);
    end
  endtask

  task automatic test_mid_reset;
    int budget = 3000;
    while (m_cnt != 1000 && budget > 0) begin
      step(1'($urandom_range(0, 3) != 0), 1'b1);
      budget--;
      checks++;
      if (data !== exp_d || fancy_data !== exp_f) begin
        errors++;
        $display("FAIL to_1000: data=%0d fancy=%0d expected data=%0d fancy=%0d", data, fancy_data, exp_d, exp_f);
      end
    end
    checks++;
    if (data !== 16'd1000) begin
      errors++;
      $display("FAIL reach_1000: data=%0d expected 1000", data);
    end
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b0);
      checks++;
      if (data !== 16'd0 || fancy_data !== 16'd17) begin
        errors++;
        $display("FAIL mid_reset[%0d]: data=%0d fancy=%0d expected data=0 fancy=17", i, data, fancy_data);
      end
    end
    step(1'b1, 1'b1);
    checks++;
    if (data !== 16'd1 || fancy_data !== 16'd1287) begin
      errors++;
      $display("FAIL resume_1: data=%0d fancy=%0d expected data=1 fancy=1287", data, fancy_data);
    end
    step(1'b1, 1'b1);
    checks++;
    if (data !== 16'd2 || fancy_data !== 16'd5) begin
      errors++;
      $display("FAIL resume_2: data=%0d fancy=%0d expected data=2 fancy=5", data, fancy_data);
    end
  endtask

  // Wiggle nreset/enable between edges; outputs must not move until an edge.
  task automatic test_no_async;
    step(1'b1, 1'b1);
    nreset = 1'b0;
    enable = 1'b0;
    #2;
    checks++;
    if (data !== exp_d || fancy_data !== exp_f) begin
      errors++;
      $display("FAIL no_async_reset: data=%0d fancy=%0d expected data=%0d fancy=%0d", data, fancy_data, exp_d, exp_f);
    end
    nreset = 1'b1;
    enable = 1'b1;
    #2;
    checks++;
    if (data !== exp_d || fancy_data !== exp_f) begin
      errors++;
      $display("FAIL no_async_enable: data=%0d fancy=%0d expected data=%0d fancy=%0d", data, fancy_data, exp_d, exp_f);
    end
  endtask

  task automatic test_full_wrap;
    logic [15:0] td [4];
    logic [15:0] tf [4];
    int budget = 80000;
    td = '{16'hFFFF, 16'h0000, 16'h0001, 16'h0002};
    tf = '{16'h0000, 16'd17, 16'd1287, 16'd5};
    while (m_cnt != 16'hFFFE && budget > 0) begin
      step(1'($urandom_range(0, 31) != 0), 1'b1);
      budget--;
      checks++;
      if (data !== exp_d || fancy_data !== exp_f) begin
        errors++;
        if (errors < 20)
          $display("FAIL long_run: data=%0h fancy=%0h expected data=%0h fancy=%0h", data, fancy_data, exp_d, exp_f);
      end
    end
    checks++;
    if (data !== 16'hFFFE) begin
      errors++;
      $display("FAIL reach_fffe: data=%0h expected fffe (budget left %0d)", data, budget);
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1);
      checks++;
      if (data !== td[i] || fancy_data !== tf[i]) begin
        errors++;
        $display("FAIL wrap[%0d]: data=%0h fancy=%0h expected data=%0h fancy=%0h",
                 i, data, fancy_data, td[i], tf[i]);
      end
    end
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) != 0));
      checks++;
      if (data !== exp_d || fancy_data !== exp_f) begin
        errors++;
        if (errors < 20)
          $display("FAIL back_to_back[%0d]: data=%0h fancy=%0h expected data=%0h fancy=%0h",
                   i, data, fancy_data, exp_d, exp_f);
      end
    end
  endtask

  initial begin
    nreset = 1'b1;
    enable = 1'b0;
    test_power_up;
    test_reset;
    test_count_from_reset;
    test_enable_low;
    test_special_17;
    test_mid_reset;
    test_no_async;
    test_full_wrap;
    test_back_to_back;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
